// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, constants and hazard helper for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam logic [7:0] MEM_TIMEOUT = 8'd255;
    localparam int         CNT_W       = 16;

    // A load feeding either ID source register; $zero never creates a dependency
    function automatic logic load_use(input logic       mem_read,
                                      input logic [4:0] idex_rt,
                                      input logic [4:0] ifid_rs,
                                      input logic [4:0] ifid_rt);
        return mem_read && (idex_rt != REG_ZERO) &&
               ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, cleared by reset
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc and stick at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, control flush and memory-wait freeze controller
module pipeline_hazard_ctrl
    import hazard_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RegisterRt_i,
    input  logic [4:0]       IFID_RegisterRs_i,
    input  logic [4:0]       IFID_RegisterRt_i,
    input  logic             Branch_taken_i,
    input  logic             Jump_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             select_o,
    output logic             IFID_flush_o,
    output logic             freeze_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_e     state;
    state_e     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;
    logic       timeout_set;
    logic       bubble_inc;
    logic       flush_inc;
    logic       hazard;

    assign hazard = load_use(IDEX_MemRead_i, IDEX_RegisterRt_i,
                             IFID_RegisterRs_i, IFID_RegisterRt_i);

    // Next state and Mealy control outputs; a pending memory access outranks
    // load-use, which in turn outranks branch/jump so the branch retries next cycle
    always_comb begin
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        timeout_set  = 1'b0;
        bubble_inc   = 1'b0;
        flush_inc    = 1'b0;
        PCWrite_o    = 1'b0;
        IFIDWrite_o  = 1'b0;
        select_o     = 1'b0;
        IFID_flush_o = 1'b0;
        freeze_o     = 1'b0;
        case (state)
            IDLE: begin
                select_o = 1'b1;
                if (start_i) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!start_i) begin
                    state_nxt = IDLE;
                end
                if (mem_req_i && !mem_ack_i) begin
                    freeze_o = 1'b1;
                    wait_nxt = 8'd0;
                    if (start_i) begin
                        state_nxt = MEM_WAIT;
                    end
                end else if (mem_req_i) begin
                    PCWrite_o   = 1'b1;
                    IFIDWrite_o = 1'b1;
                end else if (hazard) begin
                    select_o   = 1'b1;
                    bubble_inc = 1'b1;
                end else begin
                    PCWrite_o   = 1'b1;
                    IFIDWrite_o = 1'b1;
                    if (Branch_taken_i || Jump_i) begin
                        IFID_flush_o = 1'b1;
                        flush_inc    = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                freeze_o = 1'b1;
                if (!start_i) begin
                    state_nxt = IDLE;
                end else if (mem_ack_i) begin
                    state_nxt = RUN;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                    if (wait_nxt == MEM_TIMEOUT) begin
                        state_nxt   = HALT;
                        timeout_set = 1'b1;
                    end
                end
            end
            default: begin
                freeze_o = 1'b1;
            end
        endcase
    end

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            timeout_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (timeout_set) begin
                timeout_o <= 1'b1;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .inc   (bubble_inc),
        .count (bubble_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .inc   (flush_inc),
        .count (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed table and sequence checks for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        IDEX_MemRead_i;
    logic [4:0]  IDEX_RegisterRt_i;
    logic [4:0]  IFID_RegisterRs_i;
    logic [4:0]  IFID_RegisterRt_i;
    logic        Branch_taken_i;
    logic        Jump_i;
    logic        mem_req_i;
    logic        mem_ack_i;
    logic        PCWrite_o;
    logic        IFIDWrite_o;
    logic        select_o;
    logic        IFID_flush_o;
    logic        freeze_o;
    logic        timeout_o;
    logic [15:0] bubble_cnt_o;
    logic [15:0] flush_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_bub = 0;
    int exp_fl = 0;

    pipeline_hazard_ctrl dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .IDEX_MemRead_i    (IDEX_MemRead_i),
        .IDEX_RegisterRt_i (IDEX_RegisterRt_i),
        .IFID_RegisterRs_i (IFID_RegisterRs_i),
        .IFID_RegisterRt_i (IFID_RegisterRt_i),
        .Branch_taken_i    (Branch_taken_i),
        .Jump_i            (Jump_i),
        .mem_req_i         (mem_req_i),
        .mem_ack_i         (mem_ack_i),
        .PCWrite_o         (PCWrite_o),
        .IFIDWrite_o       (IFIDWrite_o),
        .select_o          (select_o),
        .IFID_flush_o      (IFID_flush_o),
        .freeze_o          (freeze_o),
        .timeout_o         (timeout_o),
        .bubble_cnt_o      (bubble_cnt_o),
        .flush_cnt_o       (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       mr;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       jmp;
        logic       req;
        logic       ack;
        logic       pcw;
        logic       ifw;
        logic       sel;
        logic       fl;
        logic       frz;
        logic       binc;
        logic       finc;
    } vec_t;

    vec_t vecs [0:10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_in(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                          input logic [4:0] rt, input logic br, input logic jmp,
                          input logic req, input logic ack);
        IDEX_MemRead_i    = mr;
        IDEX_RegisterRt_i = ex_rt;
        IFID_RegisterRs_i = rs;
        IFID_RegisterRt_i = rt;
        Branch_taken_i    = br;
        Jump_i            = jmp;
        mem_req_i         = req;
        mem_ack_i         = ack;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " idle PCWrite"}, 32'(PCWrite_o), 32'd0);
        chk({tag, " idle IFIDWrite"}, 32'(IFIDWrite_o), 32'd0);
        chk({tag, " idle select"}, 32'(select_o), 32'd1);
        chk({tag, " idle freeze"}, 32'(freeze_o), 32'd0);
    endtask

    initial begin
        int nfrz;
        int nwait;
        int bub0;
        int fl0;

        //         mr   ex_rt  rs     rt     br   jmp  req  ack  pcw  ifw  sel  fl   frz  binc finc
        vecs[0]  = {1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = {1'b1, 5'd2, 5'd2, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = {1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = {1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = {1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = {1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = {1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = {1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = {1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = {1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = {1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_i   = 1'b0;
        start_i = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        chk_idle("reset");
        chk("reset timeout", 32'(timeout_o), 32'd0);
        chk("reset bubble_cnt", 32'(bubble_cnt_o), 32'd0);
        chk("reset flush_cnt", 32'(flush_cnt_o), 32'd0);
        rst_i = 1'b1;
        step();
        chk_idle("idle hold");

        start_i = 1'b1;
        step();
        #3;
        chk("run PCWrite", 32'(PCWrite_o), 32'd1);
        chk("run flush", 32'(IFID_flush_o), 32'd0);

        for (int i = 0; i <= 10; i++) begin
            set_in(vecs[i].mr, vecs[i].ex_rt, vecs[i].rs, vecs[i].rt,
                   vecs[i].br, vecs[i].jmp, vecs[i].req, vecs[i].ack);
            #3;
            chk($sformatf("vec%0d PCWrite", i), 32'(PCWrite_o), 32'(vecs[i].pcw));
            chk($sformatf("vec%0d IFIDWrite", i), 32'(IFIDWrite_o), 32'(vecs[i].ifw));
            chk($sformatf("vec%0d select", i), 32'(select_o), 32'(vecs[i].sel));
            chk($sformatf("vec%0d flush", i), 32'(IFID_flush_o), 32'(vecs[i].fl));
            chk($sformatf("vec%0d freeze", i), 32'(freeze_o), 32'(vecs[i].frz));
            step();
            exp_bub += int'(vecs[i].binc);
            exp_fl  += int'(vecs[i].finc);
            chk($sformatf("vec%0d bubble_cnt", i), 32'(bubble_cnt_o), 32'(exp_bub));
            chk($sformatf("vec%0d flush_cnt", i), 32'(flush_cnt_o), 32'(exp_fl));
        end

        // hazard with branch: flush deferred one cycle
        set_in(1'b1, 5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        chk("hzbr cycle0 flush", 32'(IFID_flush_o), 32'd0);
        chk("hzbr cycle0 select", 32'(select_o), 32'd1);
        step();
        set_in(1'b0, 5'd0, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        chk("hzbr cycle1 flush", 32'(IFID_flush_o), 32'd1);
        step();
        exp_bub++;
        exp_fl++;
        chk("hzbr bubble_cnt", 32'(bubble_cnt_o), 32'(exp_bub));
        chk("hzbr flush_cnt", 32'(flush_cnt_o), 32'(exp_fl));

        // memory wait: ack arrives 5 cycles after the request
        nfrz = 0;
        for (int c = 0; c <= 6; c++) begin
            if (c == 0)
                set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            else if (c < 6)
                set_in(1'b1, 5'd2, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, c == 5);
            else
                set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            #3;
            if (freeze_o) nfrz++;
            if (c >= 1 && c <= 5) begin
                chk($sformatf("memwait c%0d PCWrite", c), 32'(PCWrite_o), 32'd0);
                chk($sformatf("memwait c%0d flush", c), 32'(IFID_flush_o), 32'd0);
            end
            if (c == 6) chk("memwait resume PCWrite", 32'(PCWrite_o), 32'd1);
            step();
        end
        chk("memwait freeze cycles", 32'(nfrz), 32'd6);
        chk("memwait bubble_cnt", 32'(bubble_cnt_o), 32'(exp_bub));
        chk("memwait flush_cnt", 32'(flush_cnt_o), 32'(exp_fl));

        // dropping start leaves RUN
        start_i = 1'b0;
        step();
        chk_idle("stop");
        start_i = 1'b1;
        step();

        // memory timeout into HALT
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        nwait = 0;
        while (!timeout_o && nwait < 400) begin
            step();
            nwait++;
        end
        chk("timeout wait cycles", 32'(nwait), 32'd255);
        for (int k = 0; k < 6; k++) begin
            start_i = k[0];
            step();
        end
        start_i = 1'b1;
        step();
        chk("halt freeze", 32'(freeze_o), 32'd1);
        chk("halt PCWrite", 32'(PCWrite_o), 32'd0);
        chk("halt timeout", 32'(timeout_o), 32'd1);
        #2;
        rst_i   = 1'b0;
        start_i = 1'b0;
        #1;
        chk_idle("halt reset");
        chk("halt reset timeout", 32'(timeout_o), 32'd0);
        #2;
        rst_i = 1'b1;
        step();
        chk_idle("after reset");

        // saturation of the bubble counter
        start_i = 1'b1;
        step();
        set_in(1'b1, 5'd9, 5'd9, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        bub0 = int'(bubble_cnt_o);
        fl0  = int'(flush_cnt_o);
        chk("sat start bubble_cnt", 32'(bub0), 32'd0);
        repeat (65535) step();
        chk("sat bubble_cnt max", 32'(bubble_cnt_o), 32'hFFFF);
        step();
        chk("sat bubble_cnt hold", 32'(bubble_cnt_o), 32'hFFFF);
        chk("sat flush_cnt", 32'(flush_cnt_o), 32'(fl0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have one clock and one reset; the reset is asynchronous and active-low, ports named clk_i and rst_i:
  clk_i  in  1  rising-edge clock.
  rst_i  in  1  asynchronous reset, active-low.
REQ-002 SHALL provide these ports:
  start_i            in   1   pipeline run enable; sampled each cycle.
  IDEX_MemRead_i     in   1   EX-stage instruction is a load.
  IDEX_RegisterRt_i  in   5   load destination register.
  IFID_RegisterRs_i  in   5   ID-stage source register Rs.
  IFID_RegisterRt_i  in   5   ID-stage source register Rt.
  Branch_taken_i     in   1   ID-stage branch resolved taken.
  Jump_i             in   1   ID-stage jump.
  mem_req_i          in   1   MEM-stage data access needs multi-cycle service.
  mem_ack_i          in   1   data memory completes the access.
  PCWrite_o          out  1   PC update enable.
  IFIDWrite_o        out  1   IF/ID register write enable.
  select_o           out  1   bubble select for the ID control-signal zeroing mux.
  IFID_flush_o       out  1   clear IF/ID to a NOP.
  freeze_o           out  1   hold all pipeline registers.
  timeout_o          out  1   sticky memory-timeout error.
  bubble_cnt_o       out  16  load-use bubbles inserted, saturating.
  flush_cnt_o        out  16  control flushes issued, saturating.

Function
REQ-003 SHALL implement the FSM states IDLE, RUN, MEM_WAIT and HALT.
REQ-004 SHALL move from IDLE to RUN on the first clock edge with start_i=1; any state except HALT returns to IDLE when start_i=0.
REQ-005 SHALL hold PCWrite_o=0, IFIDWrite_o=0, select_o=1 and freeze_o=0 in IDLE.
REQ-006 SHALL detect a load-use hazard in RUN as: IDEX_MemRead_i=1, IDEX_RegisterRt_i≠0, and IDEX_RegisterRt_i equals IFID_RegisterRs_i or IFID_RegisterRt_i.
REQ-007 SHALL respond to a load-use hazard in the same cycle (Mealy): select_o=1, PCWrite_o=0, IFIDWrite_o=0, and increment bubble_cnt_o at the clock edge.
REQ-008 SHALL, in RUN with Branch_taken_i or Jump_i asserted and no load-use hazard, set IFID_flush_o=1 for that cycle and increment flush_cnt_o.
REQ-009 SHALL give load-use priority over branch/jump: suppress the flush in the hazard cycle and let the branch re-evaluate the next cycle.
REQ-010 SHALL, on mem_req_i=1 in RUN with mem_ack_i=0, enter MEM_WAIT at the next edge.
REQ-011 SHALL, in MEM_WAIT, assert freeze_o=1, PCWrite_o=0 and IFIDWrite_o=0, hold select_o=0, and suppress flush and counter updates.
REQ-012 SHALL treat mem_req_i=1 with mem_ack_i=1 in the same cycle as a single-cycle access: no MEM_WAIT entry.
REQ-013 SHALL, in MEM_WAIT, return to RUN on mem_ack_i=1; freeze_o deasserts in the cycle after the ack.
REQ-014 SHALL count MEM_WAIT cycles with an 8-bit counter cleared on entry; on reaching 255 without ack, set timeout_o and enter HALT.
REQ-015 SHALL make HALT absorbing: freeze_o=1 and PCWrite_o=0 until reset; start_i is ignored.
REQ-016 SHALL give mem_req_i priority over load-use and branch in RUN: no bubble or flush counted in that cycle.
REQ-017 SHALL saturate both 16-bit counters at 16'hFFFF with no wrap.
REQ-018 SHALL, in RUN with no event, output PCWrite_o=1, IFIDWrite_o=1 and all other control outputs 0.

Reset
REQ-019 SHALL, on rst_i low (asynchronous), enter IDLE; clear both counters, the timeout counter and timeout_o; and drive the outputs to IDLE values immediately.
REQ-020 SHALL, if reset asserts during MEM_WAIT or HALT, abandon the pending access with no residual freeze after reset release.

Structure
REQ-021 SHALL place the state enum, REG_ZERO=5'd0, MEM_TIMEOUT=8'd255 and CNT_W=16 in shared package hazard_pkg.
REQ-022 SHALL implement both event counters by instantiating one sub-module, sat_counter (parameter width, inc input, clear on reset).

Verification
REQ-023 SHALL cover these directed scenarios:
  - lw $2 then add $3,$2,$4 (IDEX_Rt=2, IFID_Rs=2) -> one cycle select_o=1, PCWrite_o=0; bubble_cnt_o=1.
  - IDEX_Rt=0 with IFID_Rs=0 and MemRead=1 -> no stall; bubble_cnt_o unchanged.
  - Load-use hazard and Branch_taken_i in the same cycle -> no flush that cycle; flush next cycle; flush_cnt_o=1.
  - mem_req_i with ack after 5 cycles -> freeze_o high for exactly 6 cycles, then RUN.
  - mem_req_i with no ack -> timeout_o=1 after 255 wait cycles; HALT persists with start_i toggling; rst_i low clears it.
  - Force 65535 bubbles then one more -> bubble_cnt_o stays 16'hFFFF.
